// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump sequencer.
package reg_dump_pkg;
  localparam int BYTE_W = 8;
  localparam int DEF_PW = 3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    CSUM,
    FINISH
  } state_t;
endpackage

// File: rtl/dump_skid_buf.sv
// Two-entry byte buffer: loads one or two bytes at once, pops the head on each handshake.
module dump_skid_buf
  import reg_dump_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_pair,
  input  logic [BYTE_W-1:0] din_a,
  input  logic [BYTE_W-1:0] din_b,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              empty,
  output logic              one
);
  logic [BYTE_W-1:0] d0_reg, d1_reg;
  logic [1:0]        cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_reg  <= '0;
      d1_reg  <= '0;
      cnt_reg <= 2'd0;
    end else if (load) begin
      d0_reg  <= din_a;
      d1_reg  <= din_b;
      cnt_reg <= load_pair ? 2'd2 : 2'd1;
    end else if (pop && cnt_reg != 2'd0) begin
      d0_reg  <= d1_reg;
      cnt_reg <= cnt_reg - 2'd1;
    end
  end

  assign head  = d0_reg;
  assign empty = (cnt_reg == 2'd0);
  assign one   = (cnt_reg == 2'd1);
endmodule

// File: rtl/reg_dump_unit.sv
// Walks a register range through both register-file read ports and streams the bytes,
// optionally followed by an 8-bit sum checksum.
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int PW      = DEF_PW,
  parameter int CSUM_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PW:0]       first_reg,
  input  logic [PW:0]       last_reg,
  output logic [PW:0]       rf_addrA,
  output logic [PW:0]       rf_addrB,
  output logic              rf_movInstr,
  output logic              rf_immVal,
  input  logic [BYTE_W-1:0] rf_datA,
  input  logic [BYTE_W-1:0] rf_datB,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int AW = PW + 1;

  state_t            state_reg;
  logic [AW-1:0]     ptr_reg, end_reg;
  logic [BYTE_W-1:0] csum_reg;
  logic              bad_reg, done_reg, err_reg;

  logic [AW-1:0]     ptr_inc;
  logic              pair_ok, range_bad, ptr_done, hs;
  logic              buf_empty, buf_one;
  logic [BYTE_W-1:0] buf_head;

  assign ptr_inc   = ptr_reg + AW'(1);
  assign pair_ok   = (ptr_inc <= end_reg);
  assign ptr_done  = (ptr_reg > end_reg);
  assign range_bad = first_reg[PW] | last_reg[PW] | (first_reg > last_reg);

  dump_skid_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_reg == READ),
    .load_pair(pair_ok),
    .din_a    (rf_datA),
    .din_b    (rf_datB),
    .pop      (hs && state_reg == SEND),
    .head     (buf_head),
    .empty    (buf_empty),
    .one      (buf_one)
  );

  assign tx_valid    = (state_reg == SEND && !buf_empty) || (state_reg == CSUM);
  assign hs          = tx_valid && tx_ready;
  assign tx_data     = (state_reg == CSUM) ? csum_reg : buf_head;
  assign rf_addrA    = (state_reg == READ) ? ptr_reg : '0;
  assign rf_addrB    = (state_reg == READ) ? ptr_inc : '0;
  assign rf_movInstr = (state_reg != IDLE);
  assign rf_immVal   = 1'b0;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign err         = err_reg;

  generate
    if (CSUM_EN != 0) begin : g_last_csum
      assign tx_last = (state_reg == CSUM);
    end else begin : g_last_data
      // Pointer already advanced past last_reg, so the lone remaining byte is the final one.
      assign tx_last = (state_reg == SEND) && buf_one && ptr_done;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      end_reg   <= '0;
      csum_reg  <= '0;
      bad_reg   <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            ptr_reg   <= first_reg;
            end_reg   <= last_reg;
            csum_reg  <= '0;
            err_reg   <= 1'b0;
            bad_reg   <= range_bad;
            state_reg <= range_bad ? FINISH : READ;
          end
        end
        READ: begin
          ptr_reg   <= ptr_reg + AW'(2);
          state_reg <= SEND;
        end
        SEND: begin
          if (hs) csum_reg <= csum_reg + buf_head;
          if (buf_empty || (buf_one && hs)) begin
            if (ptr_done) state_reg <= (CSUM_EN != 0) ? CSUM : FINISH;
            else          state_reg <= READ;
          end
        end
        CSUM: begin
          if (tx_ready) state_reg <= FINISH;
        end
        FINISH: begin
          done_reg  <= 1'b1;
          err_reg   <= bad_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: one instance with checksum, one without, same stimulus.
module tb_reg_dump_unit;
  localparam int PW = 3;
  localparam int AW = PW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_reg = '0;
  logic [AW-1:0] last_reg = '0;
  logic          tx_ready = 1'b0;

  logic [AW-1:0] a0, b0, a1, b1;
  logic [7:0]    da0, db0, da1, db1, td0, td1;
  logic          mov0, imm0, tv0, tl0, busy0, done0, err0;
  logic          mov1, imm1, tv1, tl1, busy1, done1, err1;

  // Register file preloaded with core[i] = 8'h10 + i.
  assign da0 = 8'h10 + 8'(a0);
  assign db0 = 8'h10 + 8'(b0);
  assign da1 = 8'h10 + 8'(a1);
  assign db1 = 8'h10 + 8'(b1);

  reg_dump_unit #(.PW(PW), .CSUM_EN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rf_addrA(a0), .rf_addrB(b0), .rf_movInstr(mov0), .rf_immVal(imm0),
    .rf_datA(da0), .rf_datB(db0), .tx_data(td0), .tx_valid(tv0), .tx_ready(tx_ready),
    .tx_last(tl0), .busy(busy0), .done(done0), .err(err0)
  );

  reg_dump_unit #(.PW(PW), .CSUM_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rf_addrA(a1), .rf_addrB(b1), .rf_movInstr(mov1), .rf_immVal(imm1),
    .rf_datA(da1), .rf_datB(db1), .tx_data(td1), .tx_valid(tv1), .tx_ready(tx_ready),
    .tx_last(tl1), .busy(busy1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    bit            toggle;
    int            poke;
    bit            gap;
    logic [7:0]    csum;
    bit            bad;
  } vec_t;

  vec_t vecs[11];

  task automatic do_dump(input vec_t v);
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         l0[$];
    bit         l1[$];
    int         fv = -1, hs_last = -1, donec = -1, n;
    bit         st0 = 0, st1 = 0;
    logic [7:0] pd0 = '0, pd1 = '0;
    logic       pl0 = 1'b0, pl1 = 1'b0;
    logic [7:0] eb;

    if (v.gap) begin
      @(negedge clk);
      chk("done_pulse_width", int'(done0), 0);
    end
    start = 1'b1; first_reg = v.first; last_reg = v.last; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy0), 1);
    chk("err_cleared_at_start", int'(err0), 0);
    for (int c = 1; c < 400; c++) begin
      tx_ready = v.toggle ? (c % 2 == 0) : 1'b1;
      if (c == v.poke) begin
        start = 1'b1; first_reg = 4'd5; last_reg = 4'd5;
      end else if (c == v.poke + 1) begin
        start = 1'b0; first_reg = v.first; last_reg = v.last;
      end
      if (st0) begin
        chk("stall_valid0", int'(tv0), 1);
        chk("stall_data0", int'(td0), int'(pd0));
        chk("stall_last0", int'(tl0), int'(pl0));
      end
      if (st1) begin
        chk("stall_valid1", int'(tv1), 1);
        chk("stall_data1", int'(td1), int'(pd1));
      end
      if (tv0 && fv < 0) fv = c;
      if (tv0 && tx_ready) begin q0.push_back(td0); l0.push_back(tl0); hs_last = c; end
      if (tv1 && tx_ready) begin q1.push_back(td1); l1.push_back(tl1); end
      st0 = tv0 && !tx_ready; pd0 = td0; pl0 = tl0;
      st1 = tv1 && !tx_ready; pd1 = td1; pl1 = tl1;
      if (done0) begin donec = c; break; end
      @(negedge clk);
    end
    start = 1'b0;
    if (donec < 0) chk("done_timeout", 0, 1);
    chk("err_at_done0", int'(err0), int'(v.bad));
    chk("err_held1", int'(err1), int'(v.bad));
    if (v.bad) begin
      chk("bad_no_bytes0", q0.size(), 0);
      chk("bad_no_bytes1", q1.size(), 0);
      chk("bad_done_cycle", donec, 2);
    end else begin
      n = int'(v.last) - int'(v.first) + 1;
      chk("byte_count0", q0.size(), n + 1);
      chk("byte_count1", q1.size(), n);
      chk("first_valid_cycle", fv, 2);
      chk("done_after_last_hs", donec, hs_last + 2);
      for (int i = 0; i < n; i++) begin
        eb = 8'h10 + 8'(v.first) + 8'(i);
        if (i < q0.size()) begin
          chk("data0", int'(q0[i]), int'(eb));
          chk("last0_on_data", int'(l0[i]), 0);
        end
        if (i < q1.size()) begin
          chk("data1", int'(q1[i]), int'(eb));
          chk("last1", int'(l1[i]), int'(i == n - 1));
        end
      end
      if (q0.size() == n + 1) begin
        chk("csum_byte", int'(q0[n]), int'(v.csum));
        chk("csum_last", int'(l0[n]), 1);
      end
    end
    $display("dump first=%0d last=%0d toggle=%0d bytes0=%0d bytes1=%0d first_valid=%0d done_cycle=%0d err=%0d",
             v.first, v.last, v.toggle, q0.size(), q1.size(), fv, donec, err0);
  endtask

  initial begin
    int nhs;
    //         first last  tog poke gap csum   bad
    vecs[0]  = '{4'd0, 4'd7, 0, 0, 1, 8'h9C, 0};
    vecs[1]  = '{4'd0, 4'd7, 1, 0, 1, 8'h9C, 0};
    vecs[2]  = '{4'd5, 4'd5, 0, 0, 1, 8'h15, 0};
    vecs[3]  = '{4'd6, 4'd2, 0, 0, 1, 8'h00, 1};
    vecs[4]  = '{4'd8, 4'd8, 0, 0, 1, 8'h00, 1};
    vecs[5]  = '{4'd2, 4'd3, 1, 0, 1, 8'h25, 0};
    vecs[6]  = '{4'd3, 4'd6, 0, 0, 1, 8'h52, 0};
    vecs[7]  = '{4'd7, 4'd7, 0, 0, 1, 8'h17, 0};
    vecs[8]  = '{4'd0, 4'd0, 1, 0, 1, 8'h10, 0};
    vecs[9]  = '{4'd0, 4'd7, 0, 4, 1, 8'h9C, 0};
    vecs[10] = '{4'd2, 4'd3, 0, 0, 0, 8'h25, 0};

    repeat (2) @(negedge clk);
    chk("rst_valid", int'(tv0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_last", int'(tl0), 0);
    chk("rst_data", int'(td0), 0);
    chk("rst_addrA", int'(a0), 0);
    chk("rst_mov", int'(mov0), 0);
    chk("imm_zero", int'(imm0), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) do_dump(vecs[i]);

    // Asynchronous reset after three bytes have been accepted.
    @(negedge clk);
    start = 1'b1; first_reg = 4'd0; last_reg = 4'd7; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nhs = 0;
    for (int c = 0; c < 50 && nhs < 3; c++) begin
      if (tv0 && tx_ready) nhs++;
      if (nhs < 3) @(negedge clk);
    end
    chk("rst_hs_count", nhs, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(tv0), 0);
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_valid1", int'(tv1), 0);
    chk("midrst_mov", int'(mov0), 0);
    $display("reset after %0d bytes: valid=%0d busy=%0d", nhs, tv0, busy0);
    @(negedge clk);
    rst_n = 1'b1;

    do_dump(vecs[0]);
    do_dump(vecs[9]);
    do_dump(vecs[10]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
